// File: rtl/marquee_shifter.sv
// WIDTH-bit LED marquee pattern register with a built-in step prescaler.
// Modes: hold, shift left/right, rotate left/right, bounce; load has priority.
module marquee_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  input  logic             s_in,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             dir
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] MODE_SHL = 3'd1;
  localparam logic [2:0] MODE_SHR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;
  localparam logic [2:0] MODE_BNC = 3'd5;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_rol;
  logic [WIDTH-1:0] q_ror;
  logic [WIDTH-1:0] q_next;
  logic             dir_next;

  assign q_rol = {Q[WIDTH-2:0], Q[WIDTH-1]};
  assign q_ror = {Q[0], Q[WIDTH-1:1]};

  // Pattern and direction that a step would produce; applied only on the step edge.
  always_comb begin
    q_next   = Q;
    dir_next = dir;
    case (mode)
      MODE_SHL: q_next = {Q[WIDTH-2:0], s_in};
      MODE_SHR: q_next = {s_in, Q[WIDTH-1:1]};
      MODE_ROL: q_next = q_rol;
      MODE_ROR: q_next = q_ror;
      MODE_BNC: begin
        if (!dir) begin
          if (Q[0]) begin
            dir_next = 1'b1;
            q_next   = q_rol;
          end else begin
            q_next   = q_ror;
          end
        end else begin
          if (Q[WIDTH-1]) begin
            dir_next = 1'b0;
            q_next   = q_ror;
          end else begin
            q_next   = q_rol;
          end
        end
      end
      default: ;
    endcase
  end

  // The >= compare lets a shortened period fire immediately instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q    <= '0;
      cnt  <= '0;
      tick <= 1'b0;
      dir  <= 1'b0;
    end else if (load) begin
      Q    <= p_in;
      cnt  <= '0;
      tick <= 1'b0;
      dir  <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= period) begin
      Q    <= q_next;
      dir  <= dir_next;
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_ONE;
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_marquee_shifter.sv
// Directed bench for marquee_shifter (WIDTH=8): per-cycle vector table plus
// hand-written sequences for reset, load priority, period shrink and enable.
module tb_marquee_shifter;

  localparam int W  = 8;
  localparam int CW = 27;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [CW-1:0] period;
  logic          load;
  logic [W-1:0]  p_in;
  logic          s_in;
  logic [W-1:0]  Q;
  logic          tick;
  logic          dir;

  int errors = 0;
  int checks = 0;

  marquee_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .period(period),
    .load(load), .p_in(p_in), .s_in(s_in), .Q(Q), .tick(tick), .dir(dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ld;
    logic [W-1:0]  pin;
    logic          en;
    logic [2:0]    mode;
    logic [CW-1:0] per;
    logic          sin;
    logic [W-1:0]  eq;
    logic          et;
    logic          ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void v(input logic ld, input logic [W-1:0] pin, input logic e,
                            input logic [2:0] md, input int per, input logic sin,
                            input logic [W-1:0] eq, input logic et, input logic ed);
    vec_t x;
    x.ld = ld; x.pin = pin; x.en = e; x.mode = md; x.per = CW'(per); x.sin = sin;
    x.eq = eq; x.et = et; x.ed = ed;
    tbl.push_back(x);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] pin, input logic e,
                       input logic [2:0] md, input int per, input logic sin);
    @(negedge clk);
    load = ld; p_in = pin; en = e; mode = md; period = CW'(per); s_in = sin;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks;
    int n;
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; period = '0; load = 1'b0; p_in = '0; s_in = 1'b0;

    // Shift left / right
    v(1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h01, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h03, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h07, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h0F, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h1F, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h3F, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'h7F, 1, 0);
    v(0, 8'h00, 1, 1, 0, 1, 8'hFF, 1, 0);
    v(0, 8'h00, 1, 2, 0, 0, 8'h7F, 1, 0);
    v(1, 8'h00, 1, 2, 0, 1, 8'h00, 0, 0);
    v(0, 8'h00, 1, 2, 0, 1, 8'h80, 1, 0);
    v(0, 8'h00, 1, 2, 0, 1, 8'hC0, 1, 0);
    // Rotate right, period 3
    v(1, 8'h81, 0, 0, 3, 0, 8'h81, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h81, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h81, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h81, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'hC0, 1, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'hC0, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'hC0, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'hC0, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h60, 1, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h60, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h60, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h60, 0, 0);
    v(0, 8'h00, 1, 4, 3, 0, 8'h30, 1, 0);
    // Bounce
    v(1, 8'h04, 1, 5, 0, 0, 8'h04, 0, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h02, 1, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h01, 1, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h02, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h04, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h08, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h10, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h20, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h40, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h80, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'h40, 1, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h20, 1, 0);
    // Bounce all ones flips dir each step; zero pattern stays zero
    v(1, 8'hFF, 1, 5, 0, 0, 8'hFF, 0, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'hFF, 1, 1);
    v(0, 8'h00, 1, 5, 0, 0, 8'hFF, 1, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'hFF, 1, 1);
    v(1, 8'h00, 1, 3, 0, 0, 8'h00, 0, 0);
    v(0, 8'h00, 1, 3, 0, 0, 8'h00, 1, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h00, 1, 0);
    // Hold / reserved modes still tick; en=0 freezes
    v(1, 8'h3C, 1, 0, 0, 0, 8'h3C, 0, 0);
    v(0, 8'h00, 1, 0, 0, 1, 8'h3C, 1, 0);
    v(0, 8'h00, 1, 6, 0, 1, 8'h3C, 1, 0);
    v(0, 8'h00, 1, 7, 0, 1, 8'h3C, 1, 0);
    v(0, 8'h00, 0, 1, 0, 1, 8'h3C, 0, 0);
    // dir survives non-bounce modes
    v(1, 8'h01, 1, 5, 0, 0, 8'h01, 0, 0);
    v(0, 8'h00, 1, 5, 0, 0, 8'h02, 1, 1);
    v(0, 8'h00, 1, 3, 0, 0, 8'h04, 1, 1);
    v(0, 8'h00, 1, 4, 0, 0, 8'h02, 1, 1);
    v(0, 8'h00, 1, 1, 0, 0, 8'h04, 1, 1);

    // Reset state while held
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", 32'(Q), 32'h00);
    check("rst_tick", 32'(tick), 0);
    check("rst_dir", 32'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ld, tbl[i].pin, tbl[i].en, tbl[i].mode, int'(tbl[i].per), tbl[i].sin);
      edge_wait();
      check($sformatf("vec%0d_q", i), 32'(Q), 32'(tbl[i].eq));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].et));
      check($sformatf("vec%0d_dir", i), 32'(dir), 32'(tbl[i].ed));
    end

    // Load wins over a due step, and the count restarts
    drive(1, 8'h81, 0, 4, 3, 0); edge_wait();
    drive(0, 8'h00, 1, 4, 3, 0);
    repeat (3) edge_wait();
    check("ldpri_pre_tick", 32'(tick), 0);
    drive(1, 8'h5A, 1, 4, 3, 0); edge_wait();
    check("ldpri_q", 32'(Q), 32'h5A);
    check("ldpri_tick", 32'(tick), 0);
    drive(0, 8'h00, 1, 4, 3, 0);
    ticks = 0;
    for (int c = 0; c < 3; c++) begin
      edge_wait();
      if (tick) ticks++;
    end
    check("ldpri_gap_ticks", 32'(ticks), 0);
    edge_wait();
    check("ldpri_step_tick", 32'(tick), 1);
    check("ldpri_step_q", 32'(Q), 32'h2D);

    // Period shrink mid-count fires on the next edge
    drive(1, 8'h01, 0, 3, 20, 0); edge_wait();
    drive(0, 8'h00, 1, 3, 20, 0);
    ticks = 0;
    for (int c = 0; c < 10; c++) begin
      edge_wait();
      if (tick) ticks++;
    end
    check("shrink_pre_ticks", 32'(ticks), 0);
    drive(0, 8'h00, 1, 3, 5, 0); edge_wait();
    check("shrink_tick", 32'(tick), 1);
    check("shrink_q", 32'(Q), 32'h02);

    // en low mid-count clears the prescaler and freezes Q
    edge_wait(); edge_wait(); edge_wait();
    drive(0, 8'h00, 0, 3, 5, 0);
    ticks = 0;
    for (int c = 0; c < 3; c++) begin
      edge_wait();
      if (tick) ticks++;
    end
    check("en0_ticks", 32'(ticks), 0);
    check("en0_q", 32'(Q), 32'h02);
    drive(0, 8'h00, 1, 3, 5, 0);
    ticks = 0;
    for (int c = 0; c < 5; c++) begin
      edge_wait();
      if (tick) ticks++;
    end
    check("en1_gap_ticks", 32'(ticks), 0);
    edge_wait();
    check("en1_tick", 32'(tick), 1);
    check("en1_q", 32'(Q), 32'h04);

    // Asynchronous reset mid-count with dir=1
    drive(1, 8'h01, 1, 5, 0, 0); edge_wait();
    drive(0, 8'h00, 1, 5, 0, 0); edge_wait();
    check("arst_pre_dir", 32'(dir), 1);
    drive(0, 8'h00, 1, 5, 3, 0); edge_wait(); edge_wait();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(Q), 32'h00);
    check("arst_tick", 32'(tick), 0);
    check("arst_dir", 32'(dir), 0);
    drive(0, 8'h00, 1, 3, 3, 0);
    rst_n = 1'b1;
    ticks = 0;
    for (int c = 0; c < 3; c++) begin
      edge_wait();
      if (tick) ticks++;
    end
    check("arst_gap_ticks", 32'(ticks), 0);
    edge_wait();
    check("arst_first_tick", 32'(tick), 1);
    check("arst_q_zero", 32'(Q), 32'h00);

    // Eight rotate-right steps return 0x81
    drive(1, 8'h81, 0, 4, 3, 0); edge_wait();
    drive(0, 8'h00, 1, 4, 3, 0);
    for (int s = 0; s < 8; s++) begin
      n = 0;
      do begin
        edge_wait();
        n++;
      end while (!tick && n < 10);
      check($sformatf("rot8_step%0d_cycles", s), 32'(n), 4);
    end
    check("rot8_q", 32'(Q), 32'h81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/marquee_shifter.md
Name: marquee_shifter

Overview:
- Parametrised successor to the 8-bit LED marquee shift register: WIDTH-bit pattern register with a built-in programmable step prescaler, so no separate 1 s clock divider is needed.
- Modes: hold, serial shift left/right, rotate left/right, and bounce (ping-pong). Parallel load has priority over all modes.
- Sits between the debounced switch/number logic and the LED / seven-segment display driver. Entire block runs on the single system clock; no derived clocks.

Parameters:
- WIDTH, 8, pattern width in bits (≥2).
- CNT_W, 27, prescaler counter width; must hold max period (100_000_000 for 1 s at 100 MHz).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  step enable; low = prescaler cleared, pattern frozen.
- mode  input  3  0 hold, 1 shift left, 2 shift right, 3 rotate left, 4 rotate right, 5 bounce, 6/7 reserved (= hold).
- period  input  CNT_W  step interval minus 1, in clk cycles (0 = step every cycle).
- load  input  1  synchronous parallel load strobe (level; sampled every edge).
- p_in  input  WIDTH  parallel load data.
- s_in  input  1  serial input for modes 1/2.
- Q  output  WIDTH  current pattern, registered.
- tick  output  1  registered one-cycle pulse, high in the cycle Q shows a stepped value.
- dir  output  1  bounce direction: 0 = right, 1 = left; registered.

Behaviour:
- Reset (rst_n low, asynchronous): Q=0, cnt=0, tick=0, dir=0. Holds while rst_n is low; on release, the first possible step is period+1 enabled cycles later.
- Priority per rising edge: load > step > idle.
- Load (load=1): Q<=p_in, cnt<=0, dir<=0, tick<=0. Applies regardless of en or mode.
- Prescaler, when en=1 and load=0:
  - If cnt ≥ period: step fires, cnt<=0, tick<=1.
  - Else cnt<=cnt+1, tick<=0.
  - The ≥ compare means lowering period mid-count fires on the next edge and never overruns.
- en=0 and load=0: cnt<=0, tick<=0, Q and dir hold.
- Step actions (R = Q before the edge):
  - mode 1: Q<={R[W-2:0], s_in}.
  - mode 2: Q<={s_in, R[W-1:1]}.
  - mode 3: Q<={R[W-2:0], R[W-1]}.
  - mode 4: Q<={R[0], R[W-1:1]}.
  - mode 5, dir=0: if R[0]=1, dir<=1 and rotate left; else rotate right.
  - mode 5, dir=1: if R[W-1]=1, dir<=0 and rotate right; else rotate left.
  - mode 0/6/7: Q holds; tick still pulses, so the cadence stays visible.
- dir changes only in mode 5 steps or on load/reset; other modes leave dir unchanged.
- Mode change takes effect at the next step; cnt is not disturbed.
- Q=0 in rotate/bounce stays 0; dir never flips.
- Q all ones in bounce: flips dir every step, pattern unchanged.
- s_in is sampled only on the step edge.

Test Plan:
- Reset: rst_n low mid-count, WIDTH=8 → Q=0x00, tick=0, dir=0 immediately, without waiting for a clk edge.
- Rotate right, period=3: load 0x81, mode=4, en=1 → tick every 4th cycle. Q sequence 0xC0, 0x60, 0x30; after 8 steps Q=0x81.
- Shift left with s_in=1, period=0: from Q=0x00, mode=1 → Q=0x01, 0x03, … 0xFF on consecutive cycles, tick high every cycle.
- Bounce: load 0x04, mode=5, period=0 → Q 0x02, 0x01, then 0x02 with dir=1, … 0x80, then 0x40 with dir=0.
- Load priority: load=1 on the same edge as a due step, p_in=0x5A → Q=0x5A, tick=0, cnt restarts; next step at period+1 cycles.
- Period shrink / enable: cnt=10, period changed 20→5 → tick on next edge. en=0 for 3 cycles → no tick, Q holds, cnt=0.
